// File: rtl/sysmon_drp_responder.sv
// sysmon_drp_responder: emulated SYSMON auto-sequencer with a DRP register file.
// Converts temperature, VCCINT, VCCAUX and VP in turn, following the sequence
// mask in config register 0x48, and answers DRP requests after a fixed latency.
// The DRP read-data port is named do_out because "do" is a SystemVerilog keyword.
module sysmon_drp_responder #(
  parameter int CONV_CYCLES  = 64,
  parameter int DRDY_LATENCY = 2
) (
  input  logic        s_clk,
  input  logic        s_rst_n,
  input  logic        den,
  input  logic        dwe,
  input  logic [7:0]  daddr,
  input  logic [15:0] di,
  output logic [15:0] do_out,
  output logic        drdy,
  output logic [5:0]  channel,
  output logic        eoc,
  output logic        busy,
  output logic        ot,
  input  logic [9:0]  temp_code,
  input  logic [9:0]  vccint_code,
  input  logic [9:0]  vccaux_code,
  input  logic [9:0]  vp_code
);

  localparam int CW       = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
  localparam int LW       = $clog2(DRDY_LATENCY + 1);
  localparam int NCFG     = 24;
  localparam int MASK_IDX = 8;
  localparam int OT_IDX   = 19;

  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_DONE} state_t;

  // Power-on contents of the config registers 0x40..0x57, indexed from 0x40
  function automatic logic [15:0] cfg_reset(input int idx);
    case (idx)
      0:       return 16'h3000;
      1:       return 16'h20FE;
      2:       return 16'h4000;
      8:       return 16'h0F01;
      19:      return 16'hB883;
      default: return 16'h0000;
    endcase
  endfunction

  // Sequencer state
  state_t          state_q, state_d;
  logic [CW-1:0]   conv_cnt_q, conv_cnt_d;
  logic [1:0]      cur_ch_q, cur_ch_d;
  logic            busy_q, busy_d;
  logic            eoc_q, eoc_d;
  logic [5:0]      channel_q, channel_d;
  logic            ot_q, ot_d;
  logic [9:0]      status_q [4];
  logic [9:0]      status_d [4];

  // DRP state
  logic [15:0]     cfg_q [NCFG];
  logic [15:0]     cfg_d [NCFG];
  logic [LW-1:0]   pend_cnt_q, pend_cnt_d;
  logic [15:0]     hold_q, hold_d;
  logic            drdy_q, drdy_d;
  logic [15:0]     do_q, do_d;

  // Helper nets
  logic [3:0]      seq_mask;
  logic [9:0]      ot_thresh;
  logic [9:0]      conv_code;
  logic [1:0]      first_ch;
  logic [1:0]      next_ch;
  logic            next_found;
  logic [1:0]      cand;
  logic            in_cfg;
  logic            accept;
  logic [15:0]     rd_data;
  logic [15:0]     resp_data;

  assign seq_mask  = cfg_q[MASK_IDX][11:8];
  assign ot_thresh = cfg_q[OT_IDX][15:6];
  assign in_cfg    = (daddr >= 8'h40) && (daddr <= 8'h57);
  assign accept    = den && (pend_cnt_q == '0);

  // Pick the raw sensor code belonging to the channel under conversion
  always_comb begin
    conv_code = temp_code;
    case (cur_ch_q)
      2'd0: conv_code = temp_code;
      2'd1: conv_code = vccint_code;
      2'd2: conv_code = vccaux_code;
      2'd3: conv_code = vp_code;
      default: conv_code = temp_code;
    endcase
  end

  // Find the lowest enabled channel and the next enabled one after the current channel
  always_comb begin
    first_ch   = 2'd0;
    next_ch    = cur_ch_q;
    next_found = 1'b0;
    cand       = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (seq_mask[i]) first_ch = 2'(i);
    end
    for (int i = 4; i >= 1; i--) begin
      cand = cur_ch_q + 2'(i);
      if (seq_mask[cand]) begin
        next_ch    = cand;
        next_found = 1'b1;
      end
    end
  end

  // Sequencer next state: IDLE until the mask is non-zero, CONV for CONV_CYCLES, one DONE cycle
  always_comb begin
    state_d    = state_q;
    conv_cnt_d = conv_cnt_q;
    cur_ch_d   = cur_ch_q;
    busy_d     = 1'b0;
    eoc_d      = 1'b0;
    channel_d  = channel_q;
    ot_d       = ot_q;
    status_d   = status_q;
    case (state_q)
      ST_IDLE: begin
        if (seq_mask != 4'd0) begin
          state_d    = ST_CONV;
          conv_cnt_d = '0;
          cur_ch_d   = first_ch;
          busy_d     = 1'b1;
        end
      end
      ST_CONV: begin
        busy_d = 1'b1;
        if (conv_cnt_q == CW'(CONV_CYCLES - 1)) begin
          state_d            = ST_DONE;
          busy_d             = 1'b0;
          eoc_d              = 1'b1;
          status_d[cur_ch_q] = conv_code;
          channel_d          = {4'd0, cur_ch_q};
          if (cur_ch_q == 2'd0) ot_d = (temp_code >= ot_thresh);
        end else begin
          conv_cnt_d = conv_cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (next_found) begin
          state_d    = ST_CONV;
          conv_cnt_d = '0;
          cur_ch_d   = next_ch;
          busy_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers, including the registered busy/eoc/channel/ot outputs and status values
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q    <= ST_IDLE;
      conv_cnt_q <= '0;
      cur_ch_q   <= 2'd0;
      busy_q     <= 1'b0;
      eoc_q      <= 1'b0;
      channel_q  <= 6'd0;
      ot_q       <= 1'b0;
      for (int i = 0; i < 4; i++) status_q[i] <= 10'd0;
    end else begin
      state_q    <= state_d;
      conv_cnt_q <= conv_cnt_d;
      cur_ch_q   <= cur_ch_d;
      busy_q     <= busy_d;
      eoc_q      <= eoc_d;
      channel_q  <= channel_d;
      ot_q       <= ot_d;
      status_q   <= status_d;
    end
  end

  // Register file read view as seen in the current cycle
  always_comb begin
    rd_data = 16'h0000;
    if (daddr[7:2] == 6'd0) rd_data = {status_q[daddr[1:0]], 6'b0};
    else if (in_cfg)        rd_data = cfg_q[daddr[4:0]];
  end

  // DRP handshake: accept one request at a time, commit writes at once, answer after DRDY_LATENCY
  always_comb begin
    cfg_d      = cfg_q;
    pend_cnt_d = pend_cnt_q;
    hold_d     = hold_q;
    drdy_d     = 1'b0;
    do_d       = 16'h0000;
    resp_data  = dwe ? 16'h0000 : rd_data;
    if (pend_cnt_q != '0) begin
      pend_cnt_d = pend_cnt_q - LW'(1);
      if (pend_cnt_q == LW'(1)) begin
        drdy_d = 1'b1;
        do_d   = hold_q;
      end
    end
    if (accept) begin
      if (dwe && in_cfg) cfg_d[daddr[4:0]] = di;
      if (DRDY_LATENCY == 1) begin
        drdy_d = 1'b1;
        do_d   = resp_data;
      end else begin
        pend_cnt_d = LW'(DRDY_LATENCY - 1);
        hold_d     = resp_data;
      end
    end
  end

  // DRP registers; reset drops any pending request and restores config defaults
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int i = 0; i < NCFG; i++) cfg_q[i] <= cfg_reset(i);
      pend_cnt_q <= '0;
      hold_q     <= 16'h0000;
      drdy_q     <= 1'b0;
      do_q       <= 16'h0000;
    end else begin
      cfg_q      <= cfg_d;
      pend_cnt_q <= pend_cnt_d;
      hold_q     <= hold_d;
      drdy_q     <= drdy_d;
      do_q       <= do_d;
    end
  end

  assign do_out  = do_q;
  assign drdy    = drdy_q;
  assign channel = channel_q;
  assign eoc     = eoc_q;
  assign busy    = busy_q;
  assign ot      = ot_q;

endmodule

// File: tb/tb_sysmon_drp_responder.sv
// tb_sysmon_drp_responder: vector table for register defaults, hand-written
// sequences for sequencing/handshake corner cases, and a randomized run
// checked against a behavioural model of the monitor.
module tb_sysmon_drp_responder;

  localparam int CONV   = 64;
  localparam int LAT    = 2;
  localparam int PERIOD = CONV + 1;

  logic        s_clk = 1'b0;
  logic        s_rst_n;
  logic        den, dwe;
  logic [7:0]  daddr;
  logic [15:0] di;
  logic [15:0] do_out;
  logic        drdy;
  logic [5:0]  channel;
  logic        eoc, busy, ot;
  logic [9:0]  temp_code, vccint_code, vccaux_code, vp_code;

  int checks   = 0;
  int errors   = 0;
  int edge_cnt = 0;

  // Behavioural model of the register file and sequencer outputs
  logic [15:0] m_cfg [24];
  logic [9:0]  m_st  [4];
  logic [5:0]  m_chan;
  logic        m_ot;

  typedef struct {
    logic [7:0]  addr;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] exp_do;
  } vec_t;

  vec_t vecs [16];

  sysmon_drp_responder #(.CONV_CYCLES(CONV), .DRDY_LATENCY(LAT)) dut (
    .s_clk(s_clk), .s_rst_n(s_rst_n), .den(den), .dwe(dwe), .daddr(daddr), .di(di),
    .do_out(do_out), .drdy(drdy), .channel(channel), .eoc(eoc), .busy(busy), .ot(ot),
    .temp_code(temp_code), .vccint_code(vccint_code), .vccaux_code(vccaux_code), .vp_code(vp_code)
  );

  // Free-running clock
  always #5 s_clk = ~s_clk;

  // Hard stop in case something hangs
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge s_clk);
    #1;
    edge_cnt++;
  endtask

  task automatic apply_reset();
    den     = 1'b0;
    dwe     = 1'b0;
    s_rst_n = 1'b0;
    repeat (2) step();
    s_rst_n  = 1'b1;
    edge_cnt = 0;
  endtask

  // One DRP request starting in the current cycle; returns in the drdy cycle
  task automatic drp_txn(input logic [7:0] a, input logic w, input logic [15:0] wd,
                         output logic [15:0] rd);
    den = 1'b1; dwe = w; daddr = a; di = wd;
    step();
    den = 1'b0; dwe = 1'b0;
    check_output("drdy one cycle after den", {31'd0, drdy}, 32'd0);
    step();
    check_output("drdy two cycles after den", {31'd0, drdy}, 32'd1);
    rd = do_out;
  endtask

  task automatic wait_eoc(input int budget, output logic [5:0] ch, output int waited);
    step();
    waited = 1;
    while (eoc !== 1'b1 && waited < budget) begin
      step();
      waited++;
    end
    if (eoc !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL eoc wait: got no eoc in %0d cycles, expected one", budget);
    end
    ch = channel;
  endtask

  function automatic logic [15:0] cfg_default(input int i);
    case (i)
      0:       return 16'h3000;
      1:       return 16'h20FE;
      2:       return 16'h4000;
      8:       return 16'h0F01;
      19:      return 16'hB883;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] m_read(input logic [7:0] a);
    if (a < 8'h04) return {m_st[a[1:0]], 6'b0};
    if (a >= 8'h40 && a <= 8'h57) return m_cfg[a - 8'h40];
    return 16'h0000;
  endfunction

  // Reset state, then the default register map through the vector table
  task automatic test_reset_defaults();
    logic [15:0] rd;
    vecs[0]  = '{8'h40, 1'b0, 16'h0000, 16'h3000};
    vecs[1]  = '{8'h41, 1'b0, 16'h0000, 16'h20FE};
    vecs[2]  = '{8'h42, 1'b0, 16'h0000, 16'h4000};
    vecs[3]  = '{8'h48, 1'b0, 16'h0000, 16'h0F01};
    vecs[4]  = '{8'h53, 1'b0, 16'h0000, 16'hB883};
    vecs[5]  = '{8'h00, 1'b0, 16'h0000, 16'h0000};
    vecs[6]  = '{8'h99, 1'b0, 16'h0000, 16'h0000};
    vecs[7]  = '{8'h57, 1'b0, 16'h0000, 16'h0000};
    vecs[8]  = '{8'h45, 1'b1, 16'h1234, 16'h0000};
    vecs[9]  = '{8'h45, 1'b0, 16'h0000, 16'h1234};
    vecs[10] = '{8'h01, 1'b1, 16'hFFFF, 16'h0000};
    vecs[11] = '{8'h01, 1'b0, 16'h0000, 16'h0000};
    vecs[12] = '{8'h99, 1'b1, 16'hABCD, 16'h0000};
    vecs[13] = '{8'h99, 1'b0, 16'h0000, 16'h0000};
    vecs[14] = '{8'h3F, 1'b0, 16'h0000, 16'h0000};
    vecs[15] = '{8'h58, 1'b0, 16'h0000, 16'h0000};
    s_rst_n = 1'b0; den = 1'b0; dwe = 1'b0;
    step();
    check_output("reset state outputs", {6'd0, do_out, drdy, eoc, busy, channel, ot}, 32'd0);
    s_rst_n  = 1'b1;
    edge_cnt = 0;
    check_output("busy before first edge", {31'd0, busy}, 32'd0);
    step();
    check_output("busy after first edge", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      drp_txn(vecs[i].addr, vecs[i].we, vecs[i].wdata, rd);
      check_output($sformatf("vector %0d addr 0x%0h", i, vecs[i].addr), {16'd0, rd}, {16'd0, vecs[i].exp_do});
    end
  endtask

  // Default mask with den tied to eoc and daddr tied to channel
  task automatic test_autoseq();
    logic [5:0]  exp_ch [5];
    logic [15:0] exp_do [5];
    int k, r;
    exp_ch = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd0};
    exp_do = '{16'hA800, 16'h5540, 16'hAA80, 16'h4000, 16'hA800};
    temp_code = 10'h2A0; vccint_code = 10'h155; vccaux_code = 10'h2AA; vp_code = 10'h100;
    apply_reset();
    k = 0; r = 0;
    for (int c = 0; c < 6 * PERIOD && r < 5; c++) begin
      step();
      den = 1'b0;
      if (eoc === 1'b1 && k < 5) begin
        check_output($sformatf("autoseq eoc %0d edge", k), edge_cnt, PERIOD * (k + 1));
        check_output($sformatf("autoseq eoc %0d channel", k), {26'd0, channel}, {26'd0, exp_ch[k]});
        den = 1'b1; dwe = 1'b0; daddr = {2'b00, channel};
        k++;
      end
      if (drdy === 1'b1) begin
        check_output($sformatf("autoseq drdy %0d edge", r), edge_cnt, PERIOD * (r + 1) + LAT);
        check_output($sformatf("autoseq do %0d", r), {16'd0, do_out}, {16'd0, exp_do[r]});
        r++;
      end
    end
    den = 1'b0;
    check_output("autoseq drdy count", r, 5);
    check_output("ot stays low below threshold", {31'd0, ot}, 32'd0);
  endtask

  // Mask rewritten mid-conversion, then cleared
  task automatic test_mask_change();
    logic [5:0]  ch;
    logic [15:0] rd;
    logic [5:0]  exp_seq [4];
    int waited, eoc_seen, busy_seen;
    exp_seq = '{6'd2, 6'd0, 6'd2, 6'd0};
    apply_reset();
    wait_eoc(200, ch, waited);
    check_output("mask first eoc channel", {26'd0, ch}, 32'd0);
    repeat (20) step();
    drp_txn(8'h48, 1'b1, 16'h0500, rd);
    wait_eoc(200, ch, waited);
    check_output("mask ch1 completes channel", {26'd0, ch}, 32'd1);
    check_output("mask ch1 completes edge", edge_cnt, 2 * PERIOD);
    for (int i = 0; i < 4; i++) begin
      wait_eoc(200, ch, waited);
      check_output($sformatf("mask seq %0d channel", i), {26'd0, ch}, {26'd0, exp_seq[i]});
      check_output($sformatf("mask seq %0d period", i), waited, PERIOD);
    end
    step();
    drp_txn(8'h48, 1'b1, 16'h0000, rd);
    wait_eoc(200, ch, waited);
    check_output("mask clear last channel", {26'd0, ch}, 32'd2);
    step();
    check_output("busy after mask cleared", {31'd0, busy}, 32'd0);
    eoc_seen = 0; busy_seen = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (eoc === 1'b1) eoc_seen++;
      if (busy === 1'b1) busy_seen++;
    end
    check_output("no eoc while idle", eoc_seen, 0);
    check_output("no busy while idle", busy_seen, 0);
  endtask

  // Requests arriving while one is pending
  task automatic test_back_to_back();
    logic [15:0] rd;
    apply_reset();
    repeat (2) step();
    den = 1'b1; dwe = 1'b0; daddr = 8'h40;
    step();
    check_output("b2b drdy at N+1", {31'd0, drdy}, 32'd0);
    den = 1'b1; dwe = 1'b1; daddr = 8'h41; di = 16'h1111;
    step();
    den = 1'b0; dwe = 1'b0;
    check_output("b2b drdy at N+2", {31'd0, drdy}, 32'd1);
    check_output("b2b do at N+2", {16'd0, do_out}, 32'h3000);
    step();
    check_output("b2b single drdy", {31'd0, drdy}, 32'd0);
    drp_txn(8'h41, 1'b0, 16'h0000, rd);
    check_output("b2b ignored write", {16'd0, rd}, 32'h20FE);
    step();
    den = 1'b1; dwe = 1'b0; daddr = 8'h40;
    step();
    den = 1'b0;
    step();
    check_output("b2b second read drdy", {31'd0, drdy}, 32'd1);
    check_output("b2b second read do", {16'd0, do_out}, 32'h3000);
    den = 1'b1; dwe = 1'b1; daddr = 8'h41; di = 16'h1111;
    step();
    den = 1'b0; dwe = 1'b0;
    check_output("b2b write drdy early", {31'd0, drdy}, 32'd0);
    step();
    check_output("b2b write drdy", {31'd0, drdy}, 32'd1);
    check_output("b2b write do", {16'd0, do_out}, 32'd0);
    drp_txn(8'h41, 1'b0, 16'h0000, rd);
    check_output("b2b accepted write", {16'd0, rd}, 32'h1111);
  endtask

  // Over-temperature threshold at 0x2E2 from reg 0x53 = 0xB883
  task automatic test_over_temp();
    logic [5:0] ch;
    int waited;
    temp_code = 10'h2E2; vccint_code = 10'h001; vccaux_code = 10'h002; vp_code = 10'h003;
    apply_reset();
    wait_eoc(200, ch, waited);
    check_output("ot temp eoc channel", {26'd0, ch}, 32'd0);
    check_output("ot at threshold", {31'd0, ot}, 32'd1);
    temp_code = 10'h2E1;
    for (int i = 1; i < 4; i++) begin
      wait_eoc(200, ch, waited);
      check_output($sformatf("ot held at channel %0d", i), {26'd0, ch, ot}, {26'd0, 6'(i), 1'b1});
    end
    wait_eoc(200, ch, waited);
    check_output("ot below threshold", {26'd0, ch, ot}, {26'd0, 6'd0, 1'b0});
    temp_code = 10'h3FF;
    wait_eoc(200, ch, waited);
    check_output("ot ignores vccint eoc", {26'd0, ch, ot}, {26'd0, 6'd1, 1'b0});
  endtask

  // Reset asserted while a request is pending
  task automatic test_reset_mid();
    logic [5:0]  ch;
    logic [15:0] rd;
    int waited, drdy_seen;
    temp_code = 10'h155;
    apply_reset();
    drp_txn(8'h48, 1'b1, 16'h0F03, rd);
    drp_txn(8'h48, 1'b0, 16'h0000, rd);
    check_output("mask reg rewritten", {16'd0, rd}, 32'h0F03);
    wait_eoc(200, ch, waited);
    den = 1'b1; dwe = 1'b0; daddr = 8'h00;
    step();
    den = 1'b0;
    check_output("busy before reset", {31'd0, busy}, 32'd1);
    s_rst_n = 1'b0;
    #1;
    check_output("outputs drop on reset", {6'd0, do_out, drdy, eoc, busy, channel, ot}, 32'd0);
    drdy_seen = 0;
    repeat (2) begin
      step();
      if (drdy !== 1'b0) drdy_seen++;
    end
    s_rst_n  = 1'b1;
    edge_cnt = 0;
    repeat (4) begin
      step();
      if (drdy !== 1'b0) drdy_seen++;
    end
    check_output("no drdy after reset", drdy_seen, 0);
    drp_txn(8'h48, 1'b0, 16'h0000, rd);
    check_output("mask reg after reset", {16'd0, rd}, 32'h0F01);
    drp_txn(8'h00, 1'b0, 16'h0000, rd);
    check_output("status after reset", {16'd0, rd}, 32'h0000);
  endtask

  // Random DRP traffic and random sensor codes against the model
  task automatic random_phase(input int ncycles);
    logic [9:0]  prev_code [4];
    logic        w_pend;
    logic [4:0]  w_idx;
    logic [15:0] w_val;
    logic [15:0] drdy_val;
    logic [7:0]  a;
    logic        exp_eoc, exp_drdy;
    logic [15:0] exp_do;
    int pend_until, drdy_at, e, ch, sel;
    for (int i = 0; i < 24; i++) m_cfg[i] = cfg_default(i);
    for (int i = 0; i < 4; i++) begin
      m_st[i]      = 10'd0;
      prev_code[i] = 10'($urandom_range(0, 1023));
    end
    m_chan = 6'd0; m_ot = 1'b0;
    temp_code = prev_code[0]; vccint_code = prev_code[1];
    vccaux_code = prev_code[2]; vp_code = prev_code[3];
    w_pend = 1'b0; w_idx = 5'd0; w_val = 16'd0; drdy_val = 16'd0;
    pend_until = 0; drdy_at = -1;
    apply_reset();
    for (int c = 0; c < ncycles; c++) begin
      step();
      e = edge_cnt;
      exp_eoc = (e % PERIOD == 0);
      if (exp_eoc) begin
        ch = ((e / PERIOD) - 1) % 4;
        m_st[ch] = prev_code[ch];
        m_chan   = 6'(ch);
        if (ch == 0) m_ot = (prev_code[0] >= m_cfg[19][15:6]);
      end
      if (w_pend) begin
        m_cfg[w_idx] = w_val;
        w_pend = 1'b0;
      end
      exp_drdy = (drdy_at == e);
      exp_do   = exp_drdy ? drdy_val : 16'h0000;
      check_output($sformatf("random cycle %0d {eoc,busy,ot,drdy,channel,do}", e),
                   {6'd0, eoc, busy, ot, drdy, channel, do_out},
                   {6'd0, exp_eoc, !exp_eoc, m_ot, exp_drdy, m_chan, exp_do});
      for (int i = 0; i < 4; i++) prev_code[i] = 10'($urandom_range(0, 1023));
      temp_code = prev_code[0]; vccint_code = prev_code[1];
      vccaux_code = prev_code[2]; vp_code = prev_code[3];
      den = ($urandom_range(0, 2) == 0);
      dwe = $urandom_range(0, 1) == 1;
      sel = $urandom_range(0, 9);
      if (sel < 2)      a = 8'($urandom_range(0, 3));
      else if (sel < 8) a = 8'h40 + 8'($urandom_range(0, 23));
      else              a = 8'($urandom_range(0, 255));
      if (a == 8'h48) dwe = 1'b0;
      daddr = a;
      di    = 16'($urandom_range(0, 65535));
      if (den && e >= pend_until) begin
        if (dwe) begin
          if (a >= 8'h40 && a <= 8'h57) begin
            w_pend = 1'b1;
            w_idx  = 5'(a - 8'h40);
            w_val  = di;
          end
          drdy_val = 16'h0000;
        end else begin
          drdy_val = m_read(a);
        end
        pend_until = e + LAT;
        drdy_at    = e + LAT;
      end
    end
    den = 1'b0;
    dwe = 1'b0;
  endtask

  // Test sequence
  initial begin
    s_rst_n = 1'b0; den = 1'b0; dwe = 1'b0; daddr = 8'h00; di = 16'h0000;
    temp_code = 10'd0; vccint_code = 10'd0; vccaux_code = 10'd0; vp_code = 10'd0;
    test_reset_defaults();
    test_autoseq();
    test_mask_change();
    test_back_to_back();
    test_over_temp();
    test_reset_mid();
    random_phase(1500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
